// File: rtl/vending_machine_pkg.sv
// Shared definitions for the vending machine: credit/vend state encoding,
// item prices, coin values, one-hot item codes and the decode helpers used
// by the controller.
package vending_machine_pkg;

  // Credit is tracked in 5 rs steps; VEND/VEND_CHG are terminal until reset.
  typedef enum logic [2:0] {
    CR0,
    CR5,
    CR10,
    CR15,
    CR20,
    CR25,
    VEND,
    VEND_CHG
  } state_t;

  // Amounts in rupees; 6 bits hold the worst-case sum of 25 + 10 = 35.
  localparam logic [5:0] PRICE_ITEM1 = 6'd15;
  localparam logic [5:0] PRICE_ITEM2 = 6'd20;
  localparam logic [5:0] PRICE_ITEM3 = 6'd25;
  localparam logic [5:0] PRICE_ITEM4 = 6'd30;

  localparam logic [5:0] FIVE = 6'd5;
  localparam logic [5:0] TEN  = 6'd10;

  localparam logic [3:0] ITEM1 = 4'b0001;
  localparam logic [3:0] ITEM2 = 4'b0010;
  localparam logic [3:0] ITEM3 = 4'b0100;
  localparam logic [3:0] ITEM4 = 4'b1000;

  // Price of the selected item; zero marks a selection that is not one-hot.
  function automatic logic [5:0] item_price(input logic [3:0] item);
    case (item)
      ITEM1:   return PRICE_ITEM1;
      ITEM2:   return PRICE_ITEM2;
      ITEM3:   return PRICE_ITEM3;
      ITEM4:   return PRICE_ITEM4;
      default: return '0;
    endcase
  endfunction

  // Credit held in a CR state, in rupees.
  function automatic logic [5:0] credit_of(input state_t s);
    case (s)
      CR5:     return 6'd5;
      CR10:    return 6'd10;
      CR15:    return 6'd15;
      CR20:    return 6'd20;
      CR25:    return 6'd25;
      default: return '0;
    endcase
  endfunction

  // CR state holding a given credit (only called with credit below a price).
  function automatic state_t cr_state(input logic [5:0] amount);
    case (amount)
      6'd5:    return CR5;
      6'd10:   return CR10;
      6'd15:   return CR15;
      6'd20:   return CR20;
      6'd25:   return CR25;
      default: return CR0;
    endcase
  endfunction

endpackage

// File: rtl/vending_machine.sv
// Coin-operated vending controller.
//   clock       : rising-edge system clock
//   reset       : asynchronous active-low reset, returns to CR0 with outputs low
//   item_number : one-hot item select (15/20/25/30 rs); anything else is invalid
//   five_in     : 5 rs coin, one coin per sampled edge
//   ten_in      : 10 rs coin, one coin per sampled edge
//   five_out    : registered, high while 5 rs change is owed
//   dispense    : registered, high once the item has been paid for
// Both outputs hold in the vend states until reset.
module vending_machine
  import vending_machine_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] item_number,
  input  logic       five_in,
  input  logic       ten_in,
  output logic       five_out,
  output logic       dispense
);

  state_t     state;
  state_t     next_state;
  logic [5:0] price;
  logic [5:0] coin_value;
  logic [5:0] new_credit;
  logic       coin_accepted;

  // The price follows the current selection every cycle, so switching items
  // mid-transaction keeps the credit and judges it against the new price.
  always_comb begin
    price         = item_price(item_number);
    coin_value    = ten_in ? TEN : FIVE;
    new_credit    = credit_of(state) + coin_value;
    coin_accepted = (five_in ^ ten_in) && (price != '0)
                    && (state != VEND) && (state != VEND_CHG);
    next_state    = state;
    if (coin_accepted) begin
      // credit < price and a coin is at most 10, so overpay is at most 5.
      if (new_credit < price)
        next_state = cr_state(new_credit);
      else if (new_credit == price)
        next_state = VEND;
      else
        next_state = VEND_CHG;
    end
  end

  // Outputs are registered from the next state so they rise on the same edge
  // that takes the completing coin, yet depend on state only.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= CR0;
      dispense <= 1'b0;
      five_out <= 1'b0;
    end else begin
      state    <= next_state;
      dispense <= (next_state == VEND) || (next_state == VEND_CHG);
      five_out <= (next_state == VEND_CHG);
    end
  end

endmodule

// File: tb/tb_vending_machine.sv
// Directed bench for vending_machine: a table of single-cycle vectors with
// hand-computed outputs plus hand-written asynchronous-reset sequences.
module tb_vending_machine;

  logic       clock;
  logic       reset;
  logic [3:0] item_number;
  logic       five_in;
  logic       ten_in;
  logic       five_out;
  logic       dispense;

  int unsigned tests;
  int unsigned fails;

  vending_machine dut (
    .clock       (clock),
    .reset       (reset),
    .item_number (item_number),
    .five_in     (five_in),
    .ten_in      (ten_in),
    .five_out    (five_out),
    .dispense    (dispense)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // One clock cycle of stimulus; rst pulses reset before the cycle.
  typedef struct packed {
    logic       rst;
    logic [3:0] item;
    logic       five;
    logic       ten;
    logic       exp_disp;
    logic       exp_chg;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic exp_disp, input logic exp_chg);
    tests++;
    if (dispense !== exp_disp || five_out !== exp_chg) begin
      fails++;
      $display("FAIL %s: got dispense=%b five_out=%b, expected dispense=%b five_out=%b",
               name, dispense, five_out, exp_disp, exp_chg);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    five_in = 1'b0;
    ten_in  = 1'b0;
    reset   = 1'b0;
    @(negedge clock);
    reset   = 1'b1;
  endtask

  task automatic add(input logic rst, input logic [3:0] item, input logic five,
                     input logic ten, input logic ed, input logic ec);
    vec_t v;
    v.rst = rst; v.item = item; v.five = five; v.ten = ten;
    v.exp_disp = ed; v.exp_chg = ec;
    vecs.push_back(v);
  endtask

  initial begin
    tests       = 0;
    fails       = 0;
    reset       = 1'b0;
    item_number = 4'b0000;
    five_in     = 1'b0;
    ten_in      = 1'b0;

    // Item 1: five then ten -> exact payment, held, later coins ignored.
    add(1, 4'b0001, 1, 0, 0, 0);
    add(0, 4'b0001, 0, 1, 1, 0);
    add(0, 4'b0001, 0, 0, 1, 0);
    add(0, 4'b0001, 1, 0, 1, 0);
    add(0, 4'b0010, 0, 1, 1, 0);
    // Item 2: ten, ten.
    add(1, 4'b0010, 0, 1, 0, 0);
    add(0, 4'b0010, 0, 1, 1, 0);
    // Item 3: ten, ten, five.
    add(1, 4'b0100, 0, 1, 0, 0);
    add(0, 4'b0100, 0, 1, 0, 0);
    add(0, 4'b0100, 1, 0, 1, 0);
    // Item 4: ten x3.
    add(1, 4'b1000, 0, 1, 0, 0);
    add(0, 4'b1000, 0, 1, 0, 0);
    add(0, 4'b1000, 0, 1, 1, 0);
    // Item 4: ten, ten, five (25) then ten (35) -> change.
    add(1, 4'b1000, 0, 1, 0, 0);
    add(0, 4'b1000, 0, 1, 0, 0);
    add(0, 4'b1000, 1, 0, 0, 0);
    add(0, 4'b1000, 0, 1, 1, 1);
    // Invalid items ignore coins: credit must still be 0 afterwards.
    add(1, 4'b0000, 1, 0, 0, 0);
    add(0, 4'b0011, 0, 1, 0, 0);
    add(0, 4'b0001, 0, 1, 0, 0);
    add(0, 4'b0001, 1, 0, 1, 0);
    // Both coins together are ignored, then ten, ten -> no change.
    add(1, 4'b0010, 1, 1, 0, 0);
    add(0, 4'b0010, 0, 1, 0, 0);
    add(0, 4'b0010, 0, 1, 1, 0);
    // Item change mid-transaction keeps credit: 10 on item 4, +5 on item 1.
    add(1, 4'b1000, 0, 1, 0, 0);
    add(0, 4'b0001, 1, 0, 1, 0);
    // Item 1 overpaid with ten, ten -> dispense with change.
    add(1, 4'b0001, 0, 1, 0, 0);
    add(0, 4'b0001, 0, 1, 1, 1);

    // Reset state, asynchronously applied.
    #2;
    check("reset_initial", 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) pulse_reset();
      @(negedge clock);
      item_number = vecs[i].item;
      five_in     = vecs[i].five;
      ten_in      = vecs[i].ten;
      @(posedge clock);
      #1;
      check($sformatf("vec%0d", i), vecs[i].exp_disp, vecs[i].exp_chg);
    end

    // Last vector left VEND_CHG: reset low clears outputs with no clock edge.
    @(negedge clock);
    five_in = 1'b0;
    ten_in  = 1'b0;
    #2;
    check("held_before_async_reset", 1'b1, 1'b1);
    reset = 1'b0;
    #1;
    check("async_reset_clears", 1'b0, 1'b0);

    // Coins during reset are ignored across a clock edge.
    item_number = 4'b0001;
    ten_in      = 1'b1;
    @(posedge clock);
    #1;
    check("coin_during_reset", 1'b0, 1'b0);
    @(negedge clock);
    reset  = 1'b1;
    ten_in = 1'b1;
    @(posedge clock);
    #1;
    check("first_after_reset_ten", 1'b0, 1'b0);
    @(negedge clock);
    ten_in  = 1'b0;
    five_in = 1'b1;
    @(posedge clock);
    #1;
    check("first_after_reset_five", 1'b1, 1'b0);
    @(negedge clock);
    five_in = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vending_machine.md
VENDING_MACHINE -- requirements
Module: vending_machine

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low.
REQ-002 SHALL have port: clock  input  1  rising-edge system clock.
REQ-003 SHALL have port: reset  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: item_number  input  4  one-hot item select.
- 0001 = item 1, 15 rs
- 0010 = item 2, 20 rs
- 0100 = item 3, 25 rs
- 1000 = item 4, 30 rs
REQ-005 SHALL have port: five_in  input  1  5 rs coin; one coin per clock edge sampled high.
REQ-006 SHALL have port: ten_in  input  1  10 rs coin; one coin per clock edge sampled high.
REQ-007 SHALL have port: five_out  output  1  registered; high = 5 rs change owed/returned.
REQ-008 SHALL have port: dispense  output  1  registered; high = item dispensed.

Function
REQ-009 SHALL keep credit in 5 rs units, 0..25 rs, in states CR0, CR5, CR10, CR15, CR20, CR25, plus terminal states VEND and VEND_CHG.
REQ-010 SHALL decode price from item_number combinationally each cycle; the current item applies at every edge, so an item change mid-transaction keeps credit.
REQ-011 SHALL treat any item_number that is not one-hot (0000, multi-bit) as invalid:
- coins are ignored
- credit is unchanged
- outputs stay 0
REQ-012 SHALL accept a coin only in a CR state with a valid item and exactly one of five_in/ten_in high.
REQ-013 SHALL ignore both coins, with no credit change, when five_in and ten_in are high in the same cycle.
REQ-014 SHALL compute new = credit + coin value on an accepted coin:
- if new < price: go to CR<new>
- if new == price: go to VEND
- if new == price + 5: go to VEND_CHG
REQ-015 SHALL never let new exceed price + 5, because credit < price and the coin is at most 10; no other overpay case exists.
REQ-016 SHALL drive outputs per state:
- VEND: dispense = 1, five_out = 0
- VEND_CHG: dispense = 1, five_out = 1
- CR states: both outputs 0
REQ-017 SHALL have latency of exactly one clock edge: outputs rise on the same edge that samples the completing coin.
REQ-018 SHALL hold VEND/VEND_CHG, and therefore both outputs, until reset; coins and item changes there are ignored.
REQ-019 SHALL register both outputs as a function of state only, glitch-free, with no combinational path from inputs.

Reset
REQ-020 SHALL enter CR0 immediately on reset low and drive five_out = 0 and dispense = 0, independent of clock.
REQ-021 SHALL ignore coins during reset, including reset asserted mid-transaction or during VEND (credit is discarded).
REQ-022 SHALL resume normal operation at the first rising clock edge after reset deasserts.

Structure
REQ-023 SHALL place in a shared package vending_machine_pkg:
- the state enum
- price constants PRICE_ITEM1..4 (15/20/25/30)
- coin constants FIVE/TEN
- the item one-hot codes
REQ-024 SHALL be a single module with no sub-module; price decode is a function in the package.

Verification
REQ-025 SHALL cover: item 0001, five_in for 1 cycle, then ten_in for 1 cycle -> after the ten: dispense = 1, five_out = 0, held until reset.
REQ-026 SHALL cover: item 0010, ten, ten -> after the first: 0/0; after the second: dispense = 1, five_out = 0.
REQ-027 SHALL cover: item 0100, ten, ten, five -> 0/0 until the five, then dispense = 1; also item 1000, ten ×3 -> dispense = 1 after the third.
REQ-028 SHALL cover: item 0001, ten, ten (20 rs) -> dispense = 1, five_out = 1; then reset low -> both 0 immediately.
REQ-029 SHALL cover: item 0000 with five_in pulse -> five_out = 0, dispense = 0, credit stays CR0.
REQ-030 SHALL cover: item 0010 with five_in and ten_in high together -> no credit change; then ten, ten -> dispense = 1 without change.
